// File: rtl/alu_mdu.sv
// alu_mdu: registered EX-stage ALU with a shift-add multiplier and a restoring divider (HI/LO).
// Latency: single-cycle ops 1 clock; MULT/MULTU/DIV/DIVU WIDTH+1 clocks; divide-by-zero 1 clock.
// Backpressure: in_ready drops while the MDU iterates; there is no output backpressure.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - operation handshake; operands are captured on acceptance
//   opcode, a, b, shamt - operation select, operands (a = rs, b = rt/imm), shift amount
//   out_valid           - one-cycle pulse when out/zero/overflow carry a new result
//   out, zero, overflow - registered result, result==0 flag, signed ADD/SUB overflow
//   hi, lo              - multiply/divide result registers
module alu_mdu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         opcode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out,
    output logic               zero,
    output logic               overflow,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);
    localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);

    // State
    logic [1:0]         r_state;
    logic [SHAMT_W-1:0] r_cnt;
    logic [2*WIDTH-1:0] r_acc;     // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   r_mb;      // magnitude of b (multiplicand or divisor)
    logic               r_neg_q;   // product / quotient must be negated at FIN
    logic               r_neg_r;   // remainder must be negated at FIN
    logic               r_is_div;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out;
    logic               r_zero;
    logic               r_overflow;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Single-cycle datapath
    logic [WIDTH-1:0]   w_add;
    logic [WIDTH-1:0]   w_sub;
    logic               w_slt;
    logic               w_sltu;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_ovf;

    // MDU decode / operand conditioning
    logic               w_is_mdu;
    logic               w_is_div;
    logic               w_is_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_ma;
    logic [WIDTH-1:0]   w_mb;

    // Iteration datapath
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_div_next;

    // Sign correction at FIN
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fin_hi;
    logic [WIDTH-1:0]   w_fin_lo;

    assign in_ready  = rst_n && (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign zero      = r_zero;
    assign overflow  = r_overflow;
    assign hi        = r_hi;
    assign lo        = r_lo;

    assign w_add  = a + b;
    assign w_sub  = a - b;
    assign w_slt  = $signed(a) < $signed(b);
    assign w_sltu = a < b;

    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (opcode)
            4'd0: w_alu_res = a & b;
            4'd1: w_alu_res = a | b;
            4'd2, 4'd4: begin
                w_alu_res = w_add;
                w_alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
            end
            4'd3: w_alu_res = a ^ b;
            4'd5: w_alu_res = ~(a | b);
            4'd6: begin
                w_alu_res = w_sub;
                w_alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
            end
            4'd7:    w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
            4'd8:    w_alu_res = a << shamt;
            4'd9:    w_alu_res = a >> shamt;
            4'd10:   w_alu_res = $signed(a) >>> shamt;
            4'd11:   w_alu_res = {{(WIDTH-1){1'b0}}, w_sltu};
            default: w_alu_res = '0;
        endcase
    end

    // Opcodes 12..15: bit1 selects divide, bit0 selects unsigned.
    assign w_is_mdu    = opcode[3] & opcode[2];
    assign w_is_div    = opcode[1];
    assign w_is_signed = ~opcode[0];
    assign w_a_neg     = w_is_signed & a[WIDTH-1];
    assign w_b_neg     = w_is_signed & b[WIDTH-1];
    assign w_ma        = w_a_neg ? -a : a;
    assign w_mb        = w_b_neg ? -b : b;

    // Shift-add step: add the multiplicand into the upper half when the
    // multiplier LSB is set, then shift the whole accumulator right by one.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + {1'b0, (r_acc[0] ? r_mb : {WIDTH{1'b0}})};

    // Restoring step: shift the next dividend bit into the remainder and try
    // to subtract the divisor; a clear borrow bit means the subtraction stands.
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff = w_rem_sh - {1'b0, r_mb};
    assign w_div_next = w_div_diff[WIDTH]
                      ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                      : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    // MIN / -1 needs no special case: the magnitude quotient 2^(WIDTH-1)
    // negates back onto itself.
    assign w_prod   = r_neg_q ? -r_acc : r_acc;
    assign w_quo    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_fin_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];
    assign w_fin_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mb        <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_is_div    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (!w_is_mdu) begin
                            r_out       <= w_alu_res;
                            r_zero      <= (w_alu_res == '0);
                            r_overflow  <= w_alu_ovf;
                            r_out_valid <= 1'b1;
                        end else if (w_is_div && (b == '0)) begin
                            // Divide by zero completes immediately with a fixed result.
                            r_lo        <= '1;
                            r_hi        <= a;
                            r_out       <= '1;
                            r_zero      <= 1'b0;
                            r_overflow  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            // Both algorithms start from {0, |a|}.
                            r_acc    <= {{WIDTH{1'b0}}, w_ma};
                            r_mb     <= w_mb;
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_is_div <= w_is_div;
                            r_cnt    <= CNT_LAST;
                            r_state  <= w_is_div ? S_DIV : S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    if (r_cnt == '0) begin
                        r_state <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_DIV: begin
                    r_acc <= w_div_next;
                    if (r_cnt == '0) begin
                        r_state <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_FIN: begin
                    r_hi        <= w_fin_hi;
                    r_lo        <= w_fin_lo;
                    r_out       <= w_fin_lo;
                    r_zero      <= (w_fin_lo == '0);
                    r_overflow  <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, registered successor to the pipeline's combinational EX-stage ALU. It adds a multi-cycle multiply/divide unit with HI/LO registers, a valid/ready input handshake and a registered result. Single-cycle ops sustain one result per clock. MULT/DIV occupy the unit for WIDTH+1 cycles, and the hazard unit stalls the pipeline on `in_ready` low.

## Interface
- `WIDTH`, 32: datapath width; must be ≥ 8 and a power of two.
- `SHAMT_W`, 5: shift-amount width; must equal log2(WIDTH).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `in_valid`  in  1: operation presented this cycle.
- `in_ready`  out  1: unit can accept an operation; low during reset and while MDU busy.
- `opcode`  in  4: operation select (encoding below).
- `a`, `b`  in  WIDTH: operands (`a` = rs, `b` = rt/immediate).
- `shamt`  in  SHAMT_W: shift amount for shift ops.
- `out_valid`  out  1: one-cycle pulse, result fields valid.
- `out`  out  WIDTH: registered result.
- `zero`  out  1: registered, `out == 0`.
- `overflow`  out  1: registered signed overflow; ADD/SUB only, else 0.
- `hi`, `lo`  out  WIDTH: HI/LO registers, for mfhi/mflo.

## Operation
- Opcodes, single-cycle:
  - 0 AND; 1 OR; 2 ADD; 3 XOR; 4 ADD (address calc, same as 2); 5 NOR.
  - 6 SUB (beq uses `zero`); 7 SLT signed; 8 SLL `a<<shamt`; 9 SRL; 10 SRA; 11 SLTU.
- Opcodes, multi-cycle: 12 MULT; 13 MULTU; 14 DIV; 15 DIVU.
- SLT/SLTU produce 1 or 0 in bit 0; upper bits are zero.
- Shifts act on `a` only; `b` is ignored.
- ADD/SUB wrap modulo 2^WIDTH.
- `overflow`:
  - ADD: operands have equal signs and the result sign differs.
  - SUB: operand signs differ and the result sign differs from `a`.
- Acceptance: an op is accepted on any rising edge with `in_valid && in_ready`. Operands are captured then and need not be held.
- States: IDLE, MUL, DIV, FIN.
  - IDLE: a single-cycle op registers `out`/`zero`/`overflow` and pulses `out_valid`; the unit stays in IDLE.
  - IDLE → MUL on an accepted 12/13. Signed ops take operand magnitudes and record the result sign.
  - IDLE → DIV on an accepted 14/15 with `b != 0`.
  - MUL: shift-add, one bit per cycle, 2·WIDTH-bit accumulator. A WIDTH-count counter runs down to 0, then the unit enters FIN.
  - DIV: restoring division, one quotient bit per cycle, same counter, then FIN.
  - FIN: apply sign correction (quotient sign = a^b; remainder sign = sign of `a`), write `hi`/`lo`, set `out = lo`, pulse `out_valid`, return to IDLE.
- Result placement: MULT gives `hi:lo` = full 2·WIDTH product. DIV gives `lo` = quotient, `hi` = remainder (truncating toward zero).
- Divide by zero takes no iterations: it completes like a single-cycle op, with `lo` = all ones, `hi` = `a`, `out` = all ones.
- Signed MIN/−1: `lo` = MIN, `hi` = 0, no error indication. This result falls out of the magnitude algorithm.
- `in_ready` = (state == IDLE) && reset deasserted. Single-cycle ops are never accepted while the MDU is busy.
- There is no output back-pressure; the consumer always takes `out_valid`.
- Reset, including mid-operation: state IDLE; all outputs and `hi`/`lo` = 0; the in-flight op is discarded with no `out_valid`.

## Timing
- Single-cycle op accepted at edge N: `out_valid` = 1 during cycle N..N+1; results hold until the next accepted op.
- Back-to-back single-cycle ops give one result per cycle.
- MDU op accepted at edge N:
  - `in_ready` goes low after edge N.
  - Iterations run on edges N+1..N+WIDTH; FIN commits at edge N+WIDTH+1.
  - `out_valid` pulses and `in_ready` returns high in the cycle after edge N+WIDTH+1.
  - Latency is WIDTH+1 cycles.
- A new op can be accepted in the same cycle `out_valid` is high for an MDU result.
- `hi`/`lo` are stable throughout MUL/DIV and change only at FIN, at a divide-by-zero acceptance, or at reset.
- `in_valid` with `in_ready` low is ignored; the producer must hold the op.

## Test plan
- ADD: a=0x7FFFFFFF, b=1 → `out`=0x80000000, `overflow`=1, `zero`=0, `out_valid` one cycle later. Then SUB a=5, b=5 → `out`=0, `zero`=1, `overflow`=0.
- Back-to-back stream of AND, SRA (a=0x80000000, shamt=4), SLTU (a=1, b=0xFFFFFFFF) → 0x…, 0xF8000000, 1 on consecutive cycles, `in_ready` constantly 1.
- MULT a=−3, b=7 → `in_ready` low 33 cycles, `out_valid` 33 cycles after accept, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. MULTU 0xFFFFFFFF×2 → `hi`=1, `lo`=0xFFFFFFFE.
- DIV a=−7, b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000/−1 → `lo`=0x80000000, `hi`=0. DIVU 100/0 → `out_valid` after 1 cycle, `lo`=0xFFFFFFFF, `hi`=100.
- Hold `in_valid` with an ADD during a busy DIV → ADD is not accepted until `in_ready` rises; its result appears the cycle after the DIV's `out_valid`.
- Assert `rst_n`=0 at iteration 10 of a MULT → all outputs 0 immediately, no `out_valid`, `hi`/`lo`=0, `in_ready`=1 one cycle after release.
